// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg: shared types and limits for the bit-serial arithmetic blocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_arith_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_cell.sv
// ----------------------------------------------------------------------------
// full_subtractor_cell: combinational 1-bit full subtractor (a - b - bw_in)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = a ^ b ^ bw_in;
  assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor: bit-serial LSB-first D = A - B - Bin with valid/ready I/O.
// Optional overflow flag output enabled by macro SERSUB_OVF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_subtractor: WIDTH out of range");
    end
  endgenerate

  sub_state_t       state;
  sub_state_t       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CNT_W-1:0] cnt;
  logic             bw;
  logic             bout_r;
  logic             cell_d;
  logic             cell_bw;
  logic             last_bit;

  assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);

  full_subtractor_cell u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .bw_in  (bw),
    .d      (cell_d),
    .bw_out (cell_bw)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)           state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST_CNT)    state_next = ST_DONE;
      ST_DONE: if (out_ready)          state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Datapath: operands shift right, result bits enter from the MSB side
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      bout_r <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        a_sr <= A;
        b_sr <= B;
        bw   <= Bin;
        cnt  <= '0;
      end else if (state == ST_RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        d_sr <= {cell_d, d_sr[WIDTH-1:1]};
        bw   <= cell_bw;
        cnt  <= cnt + CNT_W'(1);
        if (last_bit) begin
          bout_r <= cell_bw;
        end
      end
    end
  end

  assign D    = d_sr;
  assign Bout = bout_r;

`ifdef SERSUB_OVF_EN
  logic ovf_r;

  // Signed overflow: borrow into the MSB differs from borrow out of it
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (last_bit) begin
      ovf_r <= bw ^ cell_bw;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor: directed vector bench for serial_subtractor (WIDTH=8)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SERSUB_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ov;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and returns just after the accepting edge, with inputs scrambled
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("ready_before_op", in_ready, 1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[7]  = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[10] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_Bout", Bout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      check("vec_busy", in_ready, 0);
      wait_done(lat);
      check("vec_latency", lat, W);
      check("vec_D", D, vecs[i].d);
      check("vec_Bout", Bout, vecs[i].bout);
`ifdef SERSUB_OVF_EN
      check("vec_ovf", ovf, vecs[i].ov);
`endif
      tick();
      check("vec_idle_valid", out_valid, 0);
      check("vec_idle_ready", in_ready, 1);
    end

    // Back-to-back: in_valid held high across the first operation
    A = 8'h5A; B = 8'h3C; Bin = 1'b0; in_valid = 1'b1;
    tick();
    check("b2b_busy", in_ready, 0);
    A = 8'h33; B = 8'h11; Bin = 1'b0;
    wait_done(lat);
    check("b2b_lat1", lat, W);
    check("b2b_D1", D, 8'h1E);
    tick();
    check("b2b_hs_ready", in_ready, 1);
    check("b2b_hs_valid", out_valid, 0);
    tick();
    check("b2b_accept2", in_ready, 0);
    in_valid = 1'b0;
    wait_done(lat);
    check("b2b_lat2", lat, W);
    check("b2b_D2", D, 8'h22);
    check("b2b_Bout2", Bout, 0);
    tick();

    // Backpressure: result held while out_ready low, extra in_valid ignored
    out_ready = 1'b0;
    start_op(8'h00, 8'h01, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, W);
    in_valid = 1'b1; A = 8'h11; B = 8'h22;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_D", D, 8'hFF);
      check("bp_Bout", Bout, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_ready", in_ready, 1);

    // Reset asserted in the third RUN cycle
    start_op(8'hAA, 8'h11, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_Bout", Bout, 0);
    tick();
    check("mid_rst_stays_idle", out_valid, 0);
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(lat);
    check("post_rst_lat", lat, W);
    check("post_rst_D", D, 8'h02);
    check("post_rst_Bout", Bout, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
